nonce_dispatcher: RTL and testbench

- Scheduler that shares one nonce search across NUM_CORES parallel SHA-256d cores.
- Hands consecutive nonces to idle cores and collects their done/valid results.
- Reports the first qualifying nonce, or reports exhaustion when the nonce space wraps.
- Sits between the top-level miner controller (start/abort, result) and the SHA core array.

---
 rtl/btc_pkg.sv | 16 +
 rtl/nonce_dispatcher_if.sv | 37 +++
 rtl/lowest_set_pick.sv | 17 +
 rtl/nonce_dispatcher.sv | 136 +++++++++++++
 tb/tb_nonce_dispatcher.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btc_pkg.sv
// Shared definitions for the nonce search slice.
//   NONCE_W_DEFAULT  : default nonce width in bits
//   dispatch_state_t : dispatcher FSM states
package btc_pkg;

  localparam int NONCE_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    REPORT  = 3'd3,
    EXHAUST = 3'd4
  } dispatch_state_t;

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Bundle between the miner controller / SHA core array and the dispatcher.
//   start, abort, nonce_base     : controller requests
//   core_done, core_valid        : per-core results from the SHA array
//   core_start, core_nonce       : launch of one core with its nonce
//   busy, found, found_nonce,
//   exhausted                    : search status back to the controller
// Modports: slave = dispatcher side, master = controller/core-array side.
interface nonce_dispatcher_if
  import btc_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = NONCE_W_DEFAULT
);

  logic                 start;
  logic                 abort;
  logic [NONCE_W-1:0]   nonce_base;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_valid;
  logic [NUM_CORES-1:0] core_start;
  logic [NONCE_W-1:0]   core_nonce;
  logic                 busy;
  logic                 found;
  logic [NONCE_W-1:0]   found_nonce;
  logic                 exhausted;

  modport slave (
    input  start, abort, nonce_base, core_done, core_valid,
    output core_start, core_nonce, busy, found, found_nonce, exhausted
  );

  modport master (
    output start, abort, nonce_base, core_done, core_valid,
    input  core_start, core_nonce, busy, found, found_nonce, exhausted
  );

endinterface

// File: rtl/lowest_set_pick.sv
// Priority picker: isolates the lowest set bit of a vector.
//   vec    : candidate vector
//   onehot : one-hot of the lowest set bit (all zero when vec == 0)
//   any    : vec has at least one bit set
module lowest_set_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Two's-complement trick: vec & -vec keeps only the lowest set bit.
  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;

endmodule

// File: rtl/nonce_dispatcher.sv
// Shares one nonce search across NUM_CORES SHA-256d cores: hands consecutive
// nonces to idle cores, collects done/valid results, reports the first
// qualifying nonce or exhaustion once the nonce space wraps.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : nonce_dispatcher_if slave (controller handshake + core array)
module nonce_dispatcher
  import btc_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = NONCE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  nonce_dispatcher_if.slave bus
);

  dispatch_state_t      state_reg, state_next;
  logic [NONCE_W-1:0]   next_nonce_reg;
  logic [NUM_CORES-1:0] active_reg;
  logic [NONCE_W-1:0]   core_nonce_reg [NUM_CORES];
  logic                 hit_reg;
  logic                 wrapped_reg;
  logic [NONCE_W-1:0]   found_nonce_reg;
  logic                 exhausted_reg;

  logic [NUM_CORES-1:0] qual_done;
  logic [NUM_CORES-1:0] active_after_done;
  logic [NUM_CORES-1:0] idle_onehot;
  logic [NUM_CORES-1:0] hit_onehot;
  logic                 idle_any;
  logic                 hit_any;
  logic                 in_run;
  logic                 launch;
  logic [NONCE_W-1:0]   hit_nonce;

  // A done pulse only counts for a core we actually launched.
  assign qual_done         = bus.core_done & active_reg;
  assign active_after_done = active_reg & ~bus.core_done;

  lowest_set_pick #(.N(NUM_CORES)) u_idle_pick (
    .vec    (~active_reg),
    .onehot (idle_onehot),
    .any    (idle_any)
  );

  lowest_set_pick #(.N(NUM_CORES)) u_hit_pick (
    .vec    (qual_done & bus.core_valid),
    .onehot (hit_onehot),
    .any    (hit_any)
  );

  always_comb begin
    hit_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (hit_onehot[i]) hit_nonce = hit_nonce | core_nonce_reg[i];
    end
  end

  // Dispatch sees the registered mask, so a core finishing this cycle is
  // relaunched next cycle at the earliest. A hit or abort kills the launch.
  assign in_run = (state_reg == RUN);
  assign launch = in_run && !wrapped_reg && idle_any && !hit_any && !bus.abort;

  assign bus.core_start  = launch ? idle_onehot : '0;
  assign bus.core_nonce  = launch ? next_nonce_reg : '0;
  assign bus.busy        = (state_reg == RUN) || (state_reg == DRAIN) || (state_reg == REPORT);
  assign bus.found       = (state_reg == REPORT);
  assign bus.found_nonce = found_nonce_reg;
  assign bus.exhausted   = exhausted_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, EXHAUST: if (bus.start) state_next = RUN;
      RUN: begin
        if (bus.abort || hit_any)                     state_next = DRAIN;
        else if (wrapped_reg && active_after_done == '0) state_next = EXHAUST;
      end
      DRAIN:   if (active_after_done == '0) state_next = hit_reg ? REPORT : IDLE;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_nonce_reg  <= '0;
      active_reg      <= '0;
      hit_reg         <= 1'b0;
      wrapped_reg     <= 1'b0;
      found_nonce_reg <= '0;
      exhausted_reg   <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) core_nonce_reg[i] <= '0;
    end else begin
      active_reg <= active_after_done | (launch ? idle_onehot : '0);
      for (int i = 0; i < NUM_CORES; i++) begin
        if (launch && idle_onehot[i]) core_nonce_reg[i] <= next_nonce_reg;
      end
      case (state_reg)
        IDLE, EXHAUST: begin
          if (bus.start) begin
            next_nonce_reg  <= bus.nonce_base;
            active_reg      <= '0;
            hit_reg         <= 1'b0;
            wrapped_reg     <= 1'b0;
            exhausted_reg   <= 1'b0;
            found_nonce_reg <= '0;
          end
        end
        RUN: begin
          if (launch) begin
            next_nonce_reg <= next_nonce_reg + NONCE_W'(1);
            // Launching the all-ones nonce closes the search space.
            if (&next_nonce_reg) wrapped_reg <= 1'b1;
          end
          if (bus.abort) begin
            hit_reg <= 1'b0;
          end else if (hit_any) begin
            found_nonce_reg <= hit_nonce;
            hit_reg         <= 1'b1;
          end else if (wrapped_reg && active_after_done == '0) begin
            exhausted_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_dispatcher.sv
`timescale 1ns/1ps
module tb_nonce_dispatcher;

  localparam int NC = 4;
  localparam int NW = 32;
  localparam logic [NW-1:0] ALL_ONES = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nonce_dispatcher_if #(.NUM_CORES(NC), .NONCE_W(NW)) bus ();
  nonce_dispatcher #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Core array emulation
  int            emu_cnt   [NC];
  logic [NW-1:0] emu_nonce [NC];
  int            lat_cfg   [NC];
  bit            rnd_mode;
  int            valid_pct;
  int            spur_pct;
  logic [NW-1:0] hit_q [$];

  // Reference model of the dispatcher
  bit            m_run, m_drain, m_report;
  bit            m_hit, m_wrapped, m_exhausted;
  logic [NC-1:0] m_active;
  logic [NW-1:0] m_nonce [NC];
  logic [NW-1:0] m_next;
  logic [NW-1:0] m_found_nonce;

  // Stimulus requests (one cycle each)
  bit            req_start, req_abort, req_rst, abort_on_c0;
  logic [NW-1:0] req_base;

  // Observations of the DUT
  logic [NW-1:0] dl_nonce [$];
  int            dl_core  [$];
  int            dl_cyc   [$];
  int            done_c0  [$];
  int            dut_found_cnt;

  function automatic bit is_hit(input logic [NW-1:0] n);
    foreach (hit_q[j]) if (hit_q[j] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_report = 0;
    m_hit = 0; m_wrapped = 0; m_exhausted = 0;
    m_active = '0; m_next = '0; m_found_nonce = '0;
    for (int i = 0; i < NC; i++) m_nonce[i] = '0;
  endtask

  task automatic clear_logs();
    dl_nonce.delete(); dl_core.delete(); dl_cyc.delete(); done_c0.delete();
    dut_found_cnt = 0;
  endtask

  task automatic step();
    logic [NC-1:0] d, v, qual, hq, new_act, exp_cs;
    logic [NW-1:0] exp_cn;
    int k, hidx;
    bit launch, any_hit, old_wrapped;
    @(negedge clk);
    d = '0; v = '0;
    for (int i = 0; i < NC; i++) begin
      if (emu_cnt[i] == 1) begin
        d[i] = 1'b1;
        v[i] = rnd_mode ? ($urandom_range(0, 99) < valid_pct) : is_hit(emu_nonce[i]);
      end else if (emu_cnt[i] == 0 && spur_pct > 0 && $urandom_range(0, 99) < spur_pct) begin
        d[i] = 1'b1;
        v[i] = 1'($urandom_range(0, 1));
      end
    end
    if (abort_on_c0 && d[0]) begin
      req_abort = 1; abort_on_c0 = 0;
    end
    rst            = req_rst;
    bus.start      = req_start;
    bus.abort      = req_abort;
    bus.nonce_base = req_base;
    bus.core_done  = d;
    bus.core_valid = v;
    if (d[0]) done_c0.push_back(cyc);
    #1;
    if (req_rst) model_reset();

    qual = d & m_active;
    hq   = qual & v;
    any_hit = m_run && (hq != '0);
    hidx = -1;
    for (int i = 0; i < NC; i++) if (hq[i] && hidx < 0) hidx = i;
    k = -1;
    for (int i = 0; i < NC; i++) if (!m_active[i] && k < 0) k = i;
    launch = m_run && !m_wrapped && (k >= 0) && !req_abort && !any_hit;
    exp_cs = '0; exp_cn = '0;
    if (launch) begin exp_cs[k] = 1'b1; exp_cn = m_next; end

    chk("core_start",  64'(bus.core_start),  64'(exp_cs));
    chk("core_nonce",  64'(bus.core_nonce),  64'(exp_cn));
    chk("busy",        64'(bus.busy),        64'(m_run | m_drain | m_report));
    chk("found",       64'(bus.found),       64'(m_report));
    chk("found_nonce", 64'(bus.found_nonce), 64'(m_found_nonce));
    chk("exhausted",   64'(bus.exhausted),   64'(m_exhausted));

    if (bus.core_start != '0) begin
      for (int i = 0; i < NC; i++) if (bus.core_start[i]) dl_core.push_back(i);
      dl_nonce.push_back(bus.core_nonce);
      dl_cyc.push_back(cyc);
    end
    if (bus.found === 1'b1) dut_found_cnt++;

    if (!req_rst) begin
      old_wrapped = m_wrapped;
      new_act = m_active & ~d;
      if (launch) begin
        new_act[k] = 1'b1;
        m_nonce[k] = m_next;
        if (m_next == ALL_ONES) m_wrapped = 1;
        m_next = m_next + 1;
      end
      if (m_run) begin
        if (req_abort) begin
          m_run = 0; m_drain = 1; m_hit = 0;
        end else if (any_hit) begin
          m_found_nonce = m_nonce[hidx];
          m_hit = 1; m_run = 0; m_drain = 1;
        end else if (old_wrapped && new_act == '0) begin
          m_run = 0; m_exhausted = 1;
        end
      end else if (m_drain) begin
        if (new_act == '0) begin m_drain = 0; m_report = m_hit; end
      end else if (m_report) begin
        m_report = 0;
      end else if (req_start) begin
        m_next = req_base; new_act = '0;
        m_hit = 0; m_wrapped = 0; m_exhausted = 0; m_found_nonce = '0;
        m_run = 1;
      end
      m_active = new_act;
    end

    for (int i = 0; i < NC; i++) if (emu_cnt[i] > 0) emu_cnt[i]--;
    if (launch) begin
      emu_cnt[k]   = rnd_mode ? int'($urandom_range(1, 8)) : lat_cfg[k];
      emu_nonce[k] = exp_cn;
    end

    req_start = 0; req_abort = 0; req_rst = 0;
    cyc++;
  endtask

  task automatic run_until_quiet(input int limit, input string tag);
    int n = 0;
    while ((m_run || m_drain || m_report) && n < limit) begin
      step(); n++;
    end
    step();
    chk({tag, "_idle"}, 64'(bus.busy), 64'(0));
    $display("%s: launches=%0d found_pulses=%0d found_nonce=0x%0h exhausted=%0b",
             tag, dl_nonce.size(), dut_found_cnt, bus.found_nonce, bus.exhausted);
  endtask

  task automatic begin_search(input logic [NW-1:0] base);
    req_start = 1; req_base = base;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc, n;
    logic [NW-1:0] base;
    rst = 1'b1;
    bus.start = 0; bus.abort = 0; bus.nonce_base = '0;
    bus.core_done = '0; bus.core_valid = '0;
    for (int i = 0; i < NC; i++) begin emu_cnt[i] = 0; emu_nonce[i] = '0; lat_cfg[i] = 5; end
    rnd_mode = 0; valid_pct = 0; spur_pct = 0;
    req_start = 0; req_abort = 0; abort_on_c0 = 0; req_base = '0;
    model_reset();
    clear_logs();

    // Reset state
    req_rst = 1; step();
    step(); step();

    // Consecutive dispatch, relaunch timing, single hit on core 2
    clear_logs(); hit_q = '{32'h12}; lat_cfg = '{5, 5, 5, 5};
    s_cyc = cyc; begin_search(32'h10);
    run_until_quiet(200, "t1_dispatch_hit");
    chk("t1_launch_count", 64'(dl_nonce.size()), 64'(5));
    for (int i = 0; i < 5; i++) chk("t1_launch_nonce", 64'(dl_nonce[i]), 64'(32'h10 + i));
    for (int i = 0; i < 4; i++) chk("t1_launch_core", 64'(dl_core[i]), 64'(i));
    chk("t1_relaunch_core", 64'(dl_core[4]), 64'(0));
    chk("t1_first_launch_delay", 64'(dl_cyc[0] - s_cyc), 64'(1));
    chk("t1_back_to_back", 64'(dl_cyc[3] - dl_cyc[0]), 64'(3));
    chk("t1_relaunch_gap", 64'(dl_cyc[4] - done_c0[0]), 64'(1));
    chk("t2_found_pulses", 64'(dut_found_cnt), 64'(1));
    chk("t2_found_nonce", 64'(bus.found_nonce), 64'(32'h12));

    // Simultaneous hits on cores 1 and 3: lowest index wins
    clear_logs(); hit_q = '{32'h101, 32'h103}; lat_cfg = '{10, 6, 10, 4};
    begin_search(32'h100);
    run_until_quiet(200, "t3_tie_break");
    chk("t3_found_pulses", 64'(dut_found_cnt), 64'(1));
    chk("t3_found_nonce", 64'(bus.found_nonce), 64'(32'h101));

    // Wrap of the nonce space, then restart
    clear_logs(); hit_q.delete(); lat_cfg = '{5, 5, 5, 5};
    begin_search(32'hFFFF_FFFE);
    run_until_quiet(200, "t4_exhaust");
    chk("t4_launch_count", 64'(dl_nonce.size()), 64'(2));
    chk("t4_nonce0", 64'(dl_nonce[0]), 64'(32'hFFFF_FFFE));
    chk("t4_nonce1", 64'(dl_nonce[1]), 64'(32'hFFFF_FFFF));
    chk("t4_exhausted", 64'(bus.exhausted), 64'(1));
    chk("t4_found_pulses", 64'(dut_found_cnt), 64'(0));
    clear_logs(); hit_q = '{32'h21};
    begin_search(32'h20);
    step();
    chk("t4_exh_cleared", 64'(bus.exhausted), 64'(0));
    chk("t4_restart_busy", 64'(bus.busy), 64'(1));
    run_until_quiet(200, "t4_restart");
    chk("t4_restart_found", 64'(bus.found_nonce), 64'(32'h21));

    // Abort in the same cycle as a valid result on core 0
    clear_logs(); hit_q = '{32'h40}; lat_cfg = '{5, 8, 8, 8}; abort_on_c0 = 1;
    begin_search(32'h40);
    run_until_quiet(200, "t5_abort");
    chk("t5_found_pulses", 64'(dut_found_cnt), 64'(0));
    chk("t5_found_nonce", 64'(bus.found_nonce), 64'(0));
    chk("t5_launch_count", 64'(dl_nonce.size()), 64'(4));

    // Reset with three cores in flight, late results must be ignored
    clear_logs(); hit_q = '{32'h50, 32'h51, 32'h52, 32'h53}; lat_cfg = '{20, 20, 20, 20};
    begin_search(32'h50);
    step(); step(); step();
    req_rst = 1; step();
    for (int i = 0; i < 30; i++) step();
    $display("t6_reset: launches=%0d found_pulses=%0d busy=%0b", dl_nonce.size(), dut_found_cnt, bus.busy);
    chk("t6_launch_count", 64'(dl_nonce.size()), 64'(3));
    chk("t6_found_pulses", 64'(dut_found_cnt), 64'(0));
    chk("t6_found_nonce", 64'(bus.found_nonce), 64'(0));
    chk("t6_busy", 64'(bus.busy), 64'(0));
    chk("t6_exhausted", 64'(bus.exhausted), 64'(0));

    // Randomised searches: random latencies, results, spurious dones,
    // stray starts and aborts, occasional near-wrap bases
    rnd_mode = 1; valid_pct = 4; spur_pct = 5; hit_q.delete();
    for (int s = 0; s < 8; s++) begin
      clear_logs();
      base = (s % 3 == 2) ? (ALL_ONES - NW'($urandom_range(0, 6))) : NW'($urandom);
      begin_search(base);
      n = 0;
      while ((m_run || m_drain || m_report) && n < 600) begin
        if ($urandom_range(0, 99) < 2) req_abort = 1;
        if ($urandom_range(0, 99) < 5) begin req_start = 1; req_base = NW'($urandom); end
        if (n == 400) req_abort = 1;
        step(); n++;
      end
      run_until_quiet(50, $sformatf("rnd_search_%0d base=0x%0h", s, base));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
